// File: rtl/riscv_pkg.sv
// Shared constants and types for the riscv fetch front end.
package riscv_pkg;

   localparam int          XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] INST_NOP = 32'h0000_0013;
   localparam int          IALIGN   = 4;

   // What the fetch stage does with an incoming memory response.
   typedef enum logic [1:0] {
      RSP_NONE,
      RSP_DROP,
      RSP_PUSH,
      RSP_STRAY
   } rsp_action_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instruction} pairs ahead of decode.
// Pointers wrap naturally at DEPTH (power of 2); a separate count tells
// full from empty. Flush has priority over push and pop.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   // Next-state for pointers and occupancy; pop from empty is ignored and a
   // push into a full queue is accepted only when a pop frees a slot.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; count gates visibility so stale entries are never read out.
      if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues in-order word reads under a credit
// rule that keeps the instruction queue from overflowing, tags responses with
// their request PC, and discards responses made stale by a redirect.
module instruction_fetch_queue
   import riscv_pkg::*;
#(
   parameter int             XLEN     = riscv_pkg::XLEN,
   parameter int             DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   output logic            err_rsp
);

   localparam int              PW      = $clog2(DEPTH);
   localparam int              CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
   localparam logic [XLEN-1:0] ALIGN_M = ~(XLEN'(IALIGN - 1));

   logic [XLEN-1:0]   pc_q, pc_d;
   logic [CW-1:0]     outstanding_q, outstanding_d;
   logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
   logic              err_rsp_q, err_rsp_d;
   logic [PW-1:0]     tag_wr_q, tag_wr_d;
   logic [PW-1:0]     tag_rd_q, tag_rd_d;
   logic [XLEN-1:0]   tag_mem_q [DEPTH];

   logic [CW-1:0]     fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   logic [2*XLEN-1:0] fifo_rd_data;

   logic [CW:0]       in_use;
   logic              req_valid_int;
   logic              accept;
   logic              rsp_consumed;
   rsp_action_e       rsp_act;

   // Credit: queued + live in-flight reads must stay below DEPTH; outstanding
   // is also capped so the counters stay within 0..DEPTH after a redirect.
   assign in_use        = {1'b0, fifo_count} + {1'b0, outstanding_q} - {1'b0, drop_cnt_q};
   assign req_valid_int = !redirect_valid && !fifo_full && (in_use < DEPTH_C)
                          && ({1'b0, outstanding_q} < DEPTH_C);
   assign accept        = req_valid_int && imem_req_ready;

   assign imem_req_valid = req_valid_int && !reset;
   assign imem_req_addr  = reset ? '0 : pc_q;
   assign err_rsp        = err_rsp_q;

   assign inst_valid = !fifo_empty;
   assign inst_pc    = inst_valid ? fifo_rd_data[2*XLEN-1:XLEN] : '0;
   assign inst_data  = inst_valid ? fifo_rd_data[XLEN-1:0] : '0;

   assign fifo_push    = (rsp_act == RSP_PUSH);
   assign fifo_pop     = inst_valid && inst_ready;
   assign rsp_consumed = (rsp_act == RSP_DROP) || (rsp_act == RSP_PUSH);

   // Classify the response: stale ones first, then live ones, else stray.
   always_comb begin
      rsp_act = RSP_NONE;
      if (imem_rsp_valid) begin
         if (drop_cnt_q != '0)         rsp_act = RSP_DROP;
         else if (outstanding_q != '0) rsp_act = RSP_PUSH;
         else                          rsp_act = RSP_STRAY;
      end
   end

   // Next-state for PC, counters, tag pointers and error flag; redirect wins.
   always_comb begin
      pc_d          = pc_q;
      drop_cnt_d    = drop_cnt_q;
      err_rsp_d     = err_rsp_q;
      tag_wr_d      = tag_wr_q;
      tag_rd_d      = tag_rd_q;
      outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_consumed);
      if (accept) begin
         pc_d     = pc_q + XLEN'(IALIGN);
         tag_wr_d = tag_wr_q + PW'(1);
      end
      unique case (rsp_act)
         RSP_DROP:  drop_cnt_d = drop_cnt_q - CW'(1);
         RSP_PUSH:  tag_rd_d   = tag_rd_q + PW'(1);
         RSP_STRAY: err_rsp_d  = 1'b1;
         default:   ;
      endcase
      if (redirect_valid) begin
         pc_d          = redirect_pc & ALIGN_M;
         outstanding_d = outstanding_q - CW'(rsp_consumed);
         drop_cnt_d    = outstanding_q - CW'(rsp_consumed);
         tag_wr_d      = '0;
         tag_rd_d      = '0;
      end
   end

   // Fetch state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         err_rsp_q     <= 1'b0;
         tag_wr_q      <= '0;
         tag_rd_q      <= '0;
      end else begin
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         err_rsp_q     <= err_rsp_d;
         tag_wr_q      <= tag_wr_d;
         tag_rd_q      <= tag_rd_d;
      end
   end

   // Request-PC tag queue, read back when the matching live response returns.
   always_ff @(posedge clk) begin
      if (accept) tag_mem_q[tag_wr_q] <= pc_q;
   end

   fetch_fifo #(
      .WIDTH (2*XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .flush   (redirect_valid),
      .wr_data ({tag_mem_q[tag_rd_q], imem_rsp_data}),
      .rd_data (fifo_rd_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue with a 1..3 cycle in-order memory model.
module tb_instruction_fetch_queue;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        err_rsp;

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;

   logic [1:0]  lat_idx = 2'd0;
   logic        stray_v = 1'b0;
   logic [2:0]  st_v;
   logic [31:0] st_a [3];
   logic        acc;

   always #5 clk = ~clk;

   instruction_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .err_rsp        (err_rsp)
   );

   // Memory model: word at address a is ~a; latency = lat_idx + 1 cycles.
   assign acc            = imem_req_valid && imem_req_ready;
   assign imem_rsp_valid = st_v[lat_idx] || stray_v;
   assign imem_rsp_data  = ~st_a[lat_idx];

   always @(posedge clk or posedge reset) begin
      if (reset) st_v <= 3'b000;
      else begin
         st_v    <= {st_v[1:0], acc};
         st_a[0] <= imem_req_addr;
         st_a[1] <= st_a[0];
         st_a[2] <= st_a[1];
      end
   end

   always @(posedge clk) if (!reset && acc) acc_cnt++;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset(input logic [1:0] li, input logic rr, input logic ir);
      @(negedge clk);
      reset = 1'b1; lat_idx = li; imem_req_ready = rr; inst_ready = ir;
      redirect_valid = 1'b0; stray_v = 1'b0;
      step(); step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, err_rsp} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got rv=%b addr=%h iv=%b data=%h pc=%h err=%b exp all 0",
                  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, err_rsp);
      end
   endtask

   task automatic test_stream();
      do_reset(2'd0, 1'b1, 1'b1);
      step();
      checks++;
      if (inst_valid !== 1'b0) begin errors++; $display("FAIL fill_latency inst_valid got %b exp 0", inst_valid); end
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'(4*i), ~32'(4*i)}) begin
            errors++;
            $display("FAIL stream[%0d] got v=%b pc=%h data=%h exp v=1 pc=%h data=%h",
                     i, inst_valid, inst_pc, inst_data, 32'(4*i), ~32'(4*i));
         end
      end
      checks++;
      if (err_rsp !== 1'b0) begin errors++; $display("FAIL stream_err got %b exp 0", err_rsp); end
   endtask

   task automatic test_stall();
      int base;
      do_reset(2'd0, 1'b1, 1'b0);
      base = acc_cnt;
      repeat (10) step();
      checks++;
      if (acc_cnt - base != 4) begin errors++; $display("FAIL stall_accepts got %0d exp 4", acc_cnt - base); end
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid got %b exp 0", imem_req_valid); end
      checks++;
      if (imem_req_addr !== 32'h10) begin errors++; $display("FAIL stall_addr got %h exp 00000010", imem_req_addr); end
      checks++;
      if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h0, 32'hffff_ffff}) begin
         errors++;
         $display("FAIL stall_head got v=%b pc=%h data=%h exp v=1 pc=0 data=ffffffff", inst_valid, inst_pc, inst_data);
      end
   endtask

   // Continues from a full queue: pop and refill every cycle with no gap or loss.
   task automatic test_back_to_back();
      inst_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         checks++;
         if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'(4*i), ~32'(4*i)}) begin
            errors++;
            $display("FAIL b2b[%0d] got v=%b pc=%h data=%h exp v=1 pc=%h", i, inst_valid, inst_pc, inst_data, 32'(4*i));
         end
         step();
      end
   endtask

   task automatic test_req_stall();
      do_reset(2'd0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if ({imem_req_valid, imem_req_addr, inst_valid} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL req_hold[%0d] got rv=%b addr=%h iv=%b exp rv=1 addr=0 iv=0", i, imem_req_valid, imem_req_addr, inst_valid);
         end
      end
      imem_req_ready = 1'b1;
      step();
      checks++;
      if (imem_req_addr !== 32'h4) begin errors++; $display("FAIL req_resume_addr got %h exp 00000004", imem_req_addr); end
      step();
      checks++;
      if ({inst_valid, inst_pc} !== {1'b1, 32'h0}) begin
         errors++;
         $display("FAIL req_resume_head got v=%b pc=%h exp v=1 pc=0", inst_valid, inst_pc);
      end
   endtask

   // Redirects with reads in flight; lat_idx selects whether a response lands in the redirect cycle.
   task automatic redirect_case(input logic [1:0] li, input logic [31:0] tgt, input logic [31:0] exp_start);
      logic [31:0] exp_pc;
      int got;
      do_reset(li, 1'b1, 1'b1);
      step(); step();
      redirect_valid = 1'b1; redirect_pc = tgt;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_no_req got %b exp 0", imem_req_valid); end
      step();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, exp_start}) begin
         errors++;
         $display("FAIL redir_addr got rv=%b addr=%h exp rv=1 addr=%h", imem_req_valid, imem_req_addr, exp_start);
      end
      exp_pc = exp_start;
      got = 0;
      for (int c = 0; c < 20 && got < 3; c++) begin
         step();
         if (inst_valid) begin
            checks++;
            if ({inst_pc, inst_data} !== {exp_pc, ~exp_pc}) begin
               errors++;
               $display("FAIL redir_inst got pc=%h data=%h exp pc=%h data=%h", inst_pc, inst_data, exp_pc, ~exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
            got++;
         end
      end
      checks++;
      if (got != 3) begin errors++; $display("FAIL redir_timeout got %0d insts exp 3", got); end
   endtask

   task automatic test_redirect();
      redirect_case(2'd2, 32'h103, 32'h100);
      redirect_case(2'd1, 32'h200, 32'h200);
   endtask

   task automatic test_reset_mid();
      do_reset(2'd2, 1'b1, 1'b1);
      repeat (6) step();
      checks++;
      if (inst_valid !== 1'b1) begin errors++; $display("FAIL mid_active got %b exp 1", inst_valid); end
      reset = 1'b1;
      test_reset();
      step(); step();
      imem_req_ready = 1'b0;
      reset = 1'b0;
      #1;
      checks++;
      if (err_rsp !== 1'b0) begin errors++; $display("FAIL mid_err_pre got %b exp 0", err_rsp); end
      stray_v = 1'b1;
      step();
      stray_v = 1'b0;
      #1;
      checks++;
      if (err_rsp !== 1'b1) begin errors++; $display("FAIL stray_err got %b exp 1", err_rsp); end
      checks++;
      if ({imem_req_valid, imem_req_addr, inst_valid} !== {1'b1, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL restart got rv=%b addr=%h iv=%b exp rv=1 addr=0 iv=0", imem_req_valid, imem_req_addr, inst_valid);
      end
      step();
      checks++;
      if (err_rsp !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err_rsp); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_back_to_back();
      test_req_stall();
      test_redirect();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired after 100000 time units");
      $fatal(1);
   end

endmodule
